// File: rtl/m_pkg.sv
// m_pkg: shared types and RV32M decode constants for the PCPI multiply/divide front-end
package m_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESPOND, S_DRAIN} m_fe_state_t;
  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  function automatic logic is_m_insn(input logic [31:0] insn);
    return insn[6:0] == M_OPCODE && insn[31:25] == M_FUNCT7;
  endfunction
endpackage

// File: rtl/m_pcpi_frontend_if.sv
// m_pcpi_frontend_if: PCPI core-side and riscv_m unit-side signals of the front-end
interface m_pcpi_frontend_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_ready;
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_wr, m_rd, m_busy, m_ready,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, m_valid, m_instruction, m_rs1, m_rs2
  );
  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_wr, m_rd, m_busy, m_ready,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, m_valid, m_instruction, m_rs1, m_rs2
  );
endinterface

// File: rtl/m_result_cache.sv
// m_result_cache: one-entry last-result cache keyed on funct3/rs1/rs2, invalidated only by reset
module m_result_cache (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  f3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        hit_o,
  output logic [31:0] rd_o,
  input  logic        we_i,
  input  logic [2:0]  wf3_i,
  input  logic [31:0] wrs1_i,
  input  logic [31:0] wrs2_i,
  input  logic [31:0] wrd_i
);
  logic        vld_q;
  logic [2:0]  f3_q;
  logic [31:0] rs1_q, rs2_q, rd_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q <= 1'b0;
      f3_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (we_i) begin
      vld_q <= 1'b1;
      f3_q  <= wf3_i;
      rs1_q <= wrs1_i;
      rs2_q <= wrs2_i;
      rd_q  <= wrd_i;
    end
  end
  assign hit_o = vld_q && f3_q == f3_i && rs1_q == rs1_i && rs2_q == rs2_i;
  assign rd_o  = rd_q;
endmodule

// File: rtl/m_pcpi_frontend.sv
// m_pcpi_frontend: PCPI-to-riscv_m bridge FSM; optional last-result cache under M_FRONTEND_RESULT_CACHE_EN
module m_pcpi_frontend
  import m_pkg::*;
(
  input logic             clk,
  input logic             resetn,
  m_pcpi_frontend_if.slave bus
);
  m_fe_state_t state_q, state_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        match, hit, cache_we;
  logic [31:0] cache_rd;
  logic        unused_busy;
  assign unused_busy = bus.m_busy;
  assign match    = is_m_insn(bus.pcpi_insn);
  assign cache_we = state_q == S_WAIT && bus.m_ready && bus.m_wr;
`ifdef M_FRONTEND_RESULT_CACHE_EN
  m_result_cache u_cache (
    .clk    (clk),
    .resetn (resetn),
    .f3_i   (bus.pcpi_insn[14:12]),
    .rs1_i  (bus.pcpi_rs1),
    .rs2_i  (bus.pcpi_rs2),
    .hit_o  (hit),
    .rd_o   (cache_rd),
    .we_i   (cache_we),
    .wf3_i  (insn_q[14:12]),
    .wrs1_i (rs1_q),
    .wrs2_i (rs2_q),
    .wrd_i  (bus.m_rd)
  );
`else
  logic unused_cache;
  assign unused_cache = cache_we;
  assign hit      = 1'b0;
  assign cache_rd = '0;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: if (bus.pcpi_valid && match) begin
        if (hit) begin
          rd_d    = cache_rd;
          wr_d    = 1'b1;
          state_d = S_RESPOND;
        end else begin
          insn_d  = bus.pcpi_insn;
          rs1_d   = bus.pcpi_rs1;
          rs2_d   = bus.pcpi_rs2;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: state_d = S_WAIT;
      S_WAIT: if (bus.m_ready) begin
        rd_d    = bus.m_rd;
        wr_d    = bus.m_wr;
        state_d = bus.pcpi_valid ? S_RESPOND : S_IDLE;
      end
      S_RESPOND: state_d = S_DRAIN;
      default:   state_d = S_IDLE;
    endcase
  end
  // DRAIN holds off one cycle so the core's still-high pcpi_valid is not re-dispatched
  assign bus.m_valid       = state_q == S_DISPATCH;
  assign bus.pcpi_wait     = state_q == S_DISPATCH || state_q == S_WAIT;
  assign bus.pcpi_ready    = state_q == S_RESPOND;
  assign bus.pcpi_wr       = state_q == S_RESPOND && wr_q;
  assign bus.pcpi_rd       = state_q == S_RESPOND ? rd_q : '0;
  assign bus.m_instruction = insn_q;
  assign bus.m_rs1         = rs1_q;
  assign bus.m_rs2         = rs2_q;
endmodule

// File: doc/m_pcpi_frontend.md
# m_pcpi_frontend

PCPI front-end placed between the PicoRV32 core's PCPI port and the `riscv_m` multiply/divide unit. It decodes RV32M instructions and latches the instruction and operands. It issues a single-cycle valid pulse to the unit, captures the unit's result, and returns it to the core with the PCPI wait/ready handshake. An optional last-result cache answers a repeated identical operation without dispatching it.

## Interface
- No parameters.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `pcpi_valid` input 1: core requests coprocessor execution.
- `pcpi_insn` input 32: instruction word.
- `pcpi_rs1` input 32: operand 1.
- `pcpi_rs2` input 32: operand 2.
- `pcpi_wr` output 1: result is to be written to rd; meaningful only while `pcpi_ready` is high.
- `pcpi_rd` output 32: result value.
- `pcpi_wait` output 1: accepted instruction is in progress.
- `pcpi_ready` output 1: single-cycle completion strobe.
- `m_valid` output 1: single-cycle dispatch pulse to `riscv_m`.
- `m_instruction` output 32: latched instruction.
- `m_rs1` output 32: latched operand 1.
- `m_rs2` output 32: latched operand 2.
- `m_wr` input 1: unit write-enable.
- `m_rd` input 32: unit result.
- `m_busy` input 1: unit busy (monitor only).
- `m_ready` input 1: unit completion strobe.

## Operation
- Decode: `match` = `pcpi_insn[6:0]==7'b0110011` && `pcpi_insn[31:25]==7'b0000001`. `funct3` selects among the eight M operations.
- FSM states: IDLE, DISPATCH, WAIT, RESPOND, DRAIN.
- IDLE:
  - On `pcpi_valid && match` and a cache miss: latch insn/rs1/rs2, go to DISPATCH.
  - On a cache hit: load the result registers from the cache, go to RESPOND.
  - When `match` is low, stay in IDLE with all outputs low. The core's own timeout handles illegal instructions.
- DISPATCH: `m_valid`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On `m_ready`: capture `m_rd` and `m_wr`, and update the cache.
  - If `pcpi_valid` is still high, go to RESPOND. Otherwise (core aborted), discard the result and go to IDLE.
- RESPOND: `pcpi_ready`=1 for one cycle, with `pcpi_wr`/`pcpi_rd` driven from the result registers. Then go to DRAIN.
- DRAIN: one unconditional cycle, then go to IDLE. This prevents the still-high `pcpi_valid` from re-dispatching the same instruction.
- `pcpi_wait`=1 in DISPATCH and WAIT; 0 in all other states.
- `m_ready` is ignored outside WAIT. `m_busy` does not affect FSM transitions.
- Reset mid-operation returns the FSM to IDLE; the unit is reset on the same `resetn`.

## Timing
- Reset values: `pcpi_wr`, `pcpi_rd`, `pcpi_wait`, `pcpi_ready`, `m_valid`, `m_instruction`, `m_rs1`, `m_rs2` all 0; FSM in IDLE; cache invalid.
- Request sampled at edge N:
  - `m_valid` and `pcpi_wait` high in cycle N+1.
  - `m_ready` arrives in cycle K.
  - `pcpi_ready` is high in cycle K+1.
- Cache hit sampled at edge N: `pcpi_ready` high in cycle N+1, `pcpi_wait` never asserted.
- `m_instruction`, `m_rs1` and `m_rs2` hold their values from the accept edge until the next accept.
- `pcpi_wait` rises one cycle after acceptance, well within the core's 16-cycle limit.

## Configuration
- Macro: `M_FRONTEND_RESULT_CACHE_EN`.
- Defined: a one-entry cache holds valid, `funct3`, `rs1`, `rs2` and result.
  - Written on every WAIT completion with `m_wr`=1, including aborted completions.
  - A hit requires valid plus an exact match on all three tag fields.
  - Invalidated only by reset.
- Undefined: no cache storage; the hit signal is tied to 0 and every accepted instruction is dispatched.

## Structure
- Shared package `m_pkg`:
  - FSM state enum `m_fe_state_t`.
  - Constants `M_OPCODE`=7'b0110011 and `M_FUNCT7`=7'b0000001.
  - `funct3` encodings for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- One sub-module, `m_result_cache`: tag compare, storage and hit output. It is instantiated only under `M_FRONTEND_RESULT_CACHE_EN`.
- The FSM, decode and latches live in the top module.

## Test plan
- MUL with rs1=7, rs2=6 → one `m_valid` pulse with latched operands 7/6; unit returns 42 → `pcpi_ready` one cycle after `m_ready`, `pcpi_wr`=1, `pcpi_rd`=0x0000002A, then DRAIN and IDLE with no second dispatch.
- DIVU with rs1=5, rs2=0 → unit returns 0xFFFFFFFF → `pcpi_rd`=0xFFFFFFFF; `pcpi_wait` high from N+1 through the `m_ready` cycle.
- ADD (funct7=0), `pcpi_valid` held for 20 cycles → `m_valid`, `pcpi_wait` and `pcpi_ready` stay 0 throughout.
- Cache enabled: MULH 0x80000000 × 0x80000000 completes with `pcpi_rd`=0x40000000; the identical instruction reissued → `pcpi_ready` in cycle N+1, no `m_valid`, same result. Changing rs2 to 1 → normal dispatch.
- `pcpi_valid` dropped during WAIT, then `m_ready` → no `pcpi_ready`, FSM returns to IDLE, next request proceeds normally.
- `resetn` low for one cycle during WAIT → all outputs 0 and FSM in IDLE on the next edge; a later `m_ready` without a new dispatch produces no `pcpi_ready`.
